// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the FETCH->EX pipeline: squashes the wrong-path slot after a
// taken jump, holds the pipe around the iterative multiplier, and counts stalled cycles.
module pipeline_sequencer #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MUL_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_jump,
    input  logic [3:0]       ex_aluop,
    input  logic             mul_done,
    output logic             stall_EX,
    output logic             fetch_hold,
    output logic             mul_start,
    output logic             mul_err,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {RUN, FLUSH, MUL_WAIT, MUL_WB} state_t;

    state_t     state, next_state;
    logic [3:0] flush_cnt;
    logic [7:0] wait_cnt;
    logic       is_mul, is_jmp;
    logic       mul_timeout;

    assign is_jmp      = ex_valid & ex_jump;
    assign is_mul      = ex_valid & (ex_aluop inside {4'b0101, 4'b0110, 4'b0111});
    assign mul_timeout = (wait_cnt == 8'(MUL_TIMEOUT - 1));

    // NOTE: every output of this block gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        stall_EX   = 1'b0;
        fetch_hold = 1'b0;
        mul_start  = 1'b0;
        case (state)
            RUN: begin
                // The jump itself must write back (jal link), so it beats a mul decode.
                if (is_jmp) begin
                    next_state = FLUSH;
                end else if (is_mul) begin
                    mul_start  = 1'b1;
                    stall_EX   = 1'b1;
                    fetch_hold = 1'b1;
                    next_state = MUL_WAIT;
                end
            end
            FLUSH: begin
                stall_EX = 1'b1;
                if (flush_cnt == 4'd0) next_state = RUN;
            end
            MUL_WAIT: begin
                stall_EX   = 1'b1;
                fetch_hold = 1'b1;
                if (mul_done || mul_timeout) next_state = mul_done ? MUL_WB : RUN;
            end
            MUL_WB: begin
                fetch_hold = 1'b1;
                next_state = RUN;
            end
            default: next_state = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            mul_err     <= 1'b0;
            stall_count <= '0;
        end else begin
            state <= next_state;

            if (state == RUN && is_jmp)
                flush_cnt <= 4'(FLUSH_CYCLES - 1);
            else if (state == FLUSH && flush_cnt != 4'd0)
                flush_cnt <= flush_cnt - 4'd1;

            if (state == RUN && is_mul && !is_jmp)
                wait_cnt <= '0;
            else if (state == MUL_WAIT && !mul_done && !mul_timeout)
                wait_cnt <= wait_cnt + 8'd1;

            // A timed-out result is dropped; the error stays until the next reset.
            if (state == MUL_WAIT && !mul_done && mul_timeout)
                mul_err <= 1'b1;

            if ((stall_EX || fetch_hold) && stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
